// File: rtl/flash_timer_gen_pkg.sv
// Shared state encoding and default tick length for the flash timer.
package flash_timer_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PRESCALE_1MS = 50000;

endpackage

// File: rtl/flash_timer_gen_tick_prescaler.sv
// Free-running tick divider: tick is high for one cycle every PRESCALE cycles.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic CLK_50MHZ,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(PRESCALE - 1));

endmodule

// File: rtl/flash_timer_gen.sv
// Programmable blink sequencer for the scoreboard display.
// Optional macro RETRIGGER_EN: a start while running restarts the sequence.
module flash_timer_gen
  import flash_timer_gen_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_1MS,
  parameter int LEN_W    = 16,
  parameter int REP_W    = 4
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             start,
  input  logic             cancel,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             busy,
  output logic             flash,
  output logic             done
);

`ifdef RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q, tcnt;
  logic [REP_W-1:0] reps_q, rem;
  logic             tick, clr, load, dec_rem, accept, half_end;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .clr       (clr),
    .tick      (tick)
  );

  assign accept   = start && (len != '0) && !cancel;
  assign half_end = tick && (tcnt == len_q - LEN_W'(1));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec_rem    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ON;
          load       = 1'b1;
        end
      end
      ON: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (RETRIGGER && accept) begin
          state_next = ON;
          load       = 1'b1;
        end else if (half_end) begin
          state_next = OFF;
        end
      end
      OFF: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (RETRIGGER && accept) begin
          state_next = ON;
          load       = 1'b1;
        end else if (half_end) begin
          // reps_q of zero means blink until cancelled
          if (reps_q == '0) begin
            state_next = ON;
          end else if (rem == REP_W'(1)) begin
            state_next = DONE;
          end else begin
            state_next = ON;
            dec_rem    = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (RETRIGGER && accept) begin
          state_next = ON;
          load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every state entry (including a retrigger) restarts the half-period timing.
  assign clr = load || (state_next != state) || (state == IDLE);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      len_q  <= '0;
      reps_q <= '0;
      rem    <= '0;
      tcnt   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        len_q  <= len;
        reps_q <= reps;
        rem    <= reps;
      end else if (dec_rem) begin
        rem <= rem - REP_W'(1);
      end
      if (clr) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + LEN_W'(1);
      end
    end
  end

  assign busy  = (state == ON) || (state == OFF);
  assign flash = (state == ON);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_flash_timer_gen.sv
// Randomised self-checking bench for flash_timer_gen against a timeline model.
module tb_flash_timer_gen;

  localparam int P     = 4;
  localparam int LEN_W = 16;
  localparam int REP_W = 4;

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             cancel = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic             busy, flash, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: an accepted start at cycle m_k fixes the whole output timeline.
  bit m_act = 1'b0;
  int m_k = 0, m_len = 1, m_reps = 0;

  flash_timer_gen #(.PRESCALE(P), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .start     (start),
    .cancel    (cancel),
    .len       (len),
    .reps      (reps),
    .busy      (busy),
    .flash     (flash),
    .done      (done)
  );

  always #5 clk = ~clk;

  // 0 = idle, 1 = running, 2 = done pulse cycle
  function automatic int phase(int c);
    int off, half;
    if (!m_act) return 0;
    off  = c - m_k;
    half = m_len * P;
    if (m_reps == 0) return 1;
    if (off < 2 * half * m_reps) return 1;
    if (off == 2 * half * m_reps) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] exp_vec(int c);
    int ph;
    ph = phase(c);
    if (ph == 1) return {1'b1, (((c - m_k) / (m_len * P)) % 2 == 0), 1'b0};
    if (ph == 2) return 3'b001;
    return 3'b000;
  endfunction

  task automatic applyStimulus(input logic s, input logic c, input int l, input int r);
    int ph;
    @(negedge clk);
    start  = s;
    cancel = c;
    len    = LEN_W'(l);
    reps   = REP_W'(r);
    @(posedge clk);
    cyc++;
    ph = phase(cyc - 1);
    if (rst) begin
      m_act = 1'b0;
    end else if (ph == 1 && c) begin
      m_act = 1'b0;
    end else if (s && l != 0 && !c && (ph == 0 || RETRIG)) begin
      m_act  = 1'b1;
      m_k    = cyc;
      m_len  = l;
      m_reps = r;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] want;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 2, 1);
      total++;
      if ({busy, flash, done} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%b want=000", cyc, {busy, flash, done});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 2, 1);
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want || want !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%b want=000", cyc, {busy, flash, done});
      end
    end
  endtask

  task automatic test_basic_flash();
    int k, dones, done_at;
    logic [2:0] want;
    dones = 0;
    done_at = -1;
    applyStimulus(1'b1, 1'b0, 2, 3);
    k = cyc;
    for (int i = 0; i < 52; i++) begin
      if (i > 0) applyStimulus(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 15));
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL basic cyc=%0d off=%0d got=%b want=%b", cyc, cyc - k, {busy, flash, done}, want);
      end
      if (done === 1'b1) begin
        dones++;
        done_at = cyc - k;
      end
    end
    total++;
    if (dones != 1 || done_at != 48) begin
      bad++;
      $display("[TB] FAIL basic_done count=%0d at=%0d want count=1 at=48", dones, done_at);
    end
  endtask

  task automatic test_continuous();
    int dones, run;
    logic [2:0] want;
    dones = 0;
    applyStimulus(1'b1, 1'b0, 1, 0);
    run = 84 + $urandom_range(0, 7);
    for (int i = 0; i < run; i++) begin
      applyStimulus(1'b0, 1'b0, 1, 0);
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL continuous cyc=%0d got=%b want=%b", cyc, {busy, flash, done}, want);
      end
      if (done === 1'b1) dones++;
    end
    applyStimulus(1'b0, 1'b1, 1, 0);
    total++;
    if ({busy, flash, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL cancel cyc=%0d got=%b want=000", cyc, {busy, flash, done});
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1, 0);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("[TB] FAIL continuous_done count=%0d want=0", dones);
    end
  endtask

  task automatic test_boundaries();
    int k, retrig_at, done_at;
    logic [2:0] want;
    applyStimulus(1'b1, 1'b0, 0, 2);
    applyStimulus(1'b0, 1'b0, 0, 2);
    total++;
    if ({busy, flash, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL len_zero got=%b want=000", {busy, flash, done});
    end
    applyStimulus(1'b1, 1'b1, 2, 2);
    total++;
    if ({busy, flash, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL start_cancel got=%b want=000", {busy, flash, done});
    end
    applyStimulus(1'b0, 1'b0, 2, 3);
    applyStimulus(1'b1, 1'b0, 2, 3);
    k = cyc;
    done_at = -1;
    retrig_at = $urandom_range(9, 14);
    for (int i = 1; i < 52; i++) begin
      applyStimulus(i == retrig_at, 1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL boundary cyc=%0d off=%0d got=%b want=%b", cyc, cyc - k, {busy, flash, done}, want);
      end
      if (done === 1'b1 && done_at < 0) done_at = cyc - k;
    end
`ifndef RETRIGGER_EN
    total++;
    if (done_at != 48) begin
      bad++;
      $display("[TB] FAIL start_in_off done_at=%0d want=48", done_at);
    end
`endif
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_async_reset();
    logic [2:0] want;
    applyStimulus(1'b1, 1'b0, 2, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2, 1);
    #2 rst = 1'b1;
    #1;
    m_act = 1'b0;
    total++;
    if ({busy, flash, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL async_rst got=%b want=000", {busy, flash, done});
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i == 2, 1'b0, 1, 1);
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL after_rst cyc=%0d got=%b want=%b", cyc, {busy, flash, done}, want);
      end
    end
  endtask

  task automatic test_retrigger();
`ifdef RETRIGGER_EN
    int j, dones;
    logic [2:0] want;
    dones = 0;
    applyStimulus(1'b1, 1'b0, 2, 2);
    for (int i = 1; i < 18; i++) applyStimulus(1'b0, 1'b0, 2, 2);
    applyStimulus(1'b1, 1'b0, 3, 1);
    j = cyc;
    for (int off = 0; off < 30; off++) begin
      if (off > 0) applyStimulus(1'b0, 1'b0, 3, 1);
      want = {(off < 24), (off < 12), (off == 24)};
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL retrigger off=%0d got=%b want=%b", cyc - j, {busy, flash, done}, want);
      end
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("[TB] FAIL retrigger_done count=%0d want=1", dones);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0] want;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 6) == 0, ($urandom % 25) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 3));
      want = exp_vec(cyc);
      total++;
      if ({busy, flash, done} !== want) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%b want=%b", cyc, {busy, flash, done}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_flash();
    test_continuous();
    test_boundaries();
    test_async_reset();
    test_retrigger();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
